// File: rtl/key_filter_pkg.sv
// Shared definitions for the key conditioner: channel state encoding and counter sizing.
package key_filter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_WAIT = 3'd1,
    PRESSED    = 3'd2,
    LONG       = 3'd3,
    REL_WAIT   = 3'd4
  } ch_state_e;

  // Counter width able to hold LONG_CYC without wrapping.
  function automatic int cnt_w(input int long_cyc);
    return $clog2(long_cyc + 1);
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce/long-press FSM and registered event outputs.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int ACTIVE_LOW = 1,
  parameter int STABLE_CYC = 1_000_000,
  parameter int LONG_CYC   = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_pulse,
  output logic key_release,
  output logic key_long,
  output logic key_state
);

  localparam int              CNT_W     = cnt_w(LONG_CYC);
  localparam logic            REL_LVL   = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] LNG_LAST = CNT_W'(LONG_CYC - 1);

  logic             sync_q1, sync_q2;
  logic             p;
  ch_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] rcnt, rcnt_n;
  logic             long_seen, long_seen_n;
  logic             pulse_evt, rel_evt, long_evt;
  logic             pulse_q, rel_q, long_q, level_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= REL_LVL;
      sync_q2 <= REL_LVL;
    end else begin
      sync_q1 <= key;
      sync_q2 <= sync_q1;
    end
  end

  // p is 1 whenever the synchronised pin differs from the released level.
  assign p = sync_q2 ^ REL_LVL;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      long_seen <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      long_seen <= long_seen_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rcnt_n      = rcnt;
    long_seen_n = long_seen;
    pulse_evt   = 1'b0;
    rel_evt     = 1'b0;
    long_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (p) begin
          state_n = PRESS_WAIT;
          cnt_n   = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == STB_LAST) begin
          state_n   = PRESSED;
          cnt_n     = '0;
          pulse_evt = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      PRESSED: begin
        if (!p) begin
          state_n     = REL_WAIT;
          rcnt_n      = ONE;
          long_seen_n = 1'b0;
        end else if (cnt == LNG_LAST) begin
          state_n  = LONG;
          long_evt = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      LONG: begin
        if (!p) begin
          state_n     = REL_WAIT;
          rcnt_n      = ONE;
          long_seen_n = 1'b1;
        end
      end
      REL_WAIT: begin
        if (p) begin
          // Bounce back into the held state; the hold counter resumes this cycle.
          state_n = long_seen ? LONG : PRESSED;
          rcnt_n  = '0;
          if (!long_seen && cnt != LNG_LAST) cnt_n = cnt + ONE;
        end else if (rcnt == STB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          rcnt_n  = '0;
          rel_evt = 1'b1;
        end else begin
          rcnt_n = rcnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        rcnt_n  = '0;
      end
    endcase
  end

  // Two register stages from the FSM transition to the pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pulse_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
      level_q     <= 1'b0;
      key_pulse   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      pulse_q     <= pulse_evt;
      rel_q       <= rel_evt;
      long_q      <= long_evt;
      if (pulse_evt)    level_q <= 1'b1;
      else if (rel_evt) level_q <= 1'b0;
      key_pulse   <= pulse_q;
      key_release <= rel_q;
      key_long    <= long_q;
      key_state   <= level_q;
    end
  end

endmodule

// File: rtl/key_filter.sv
// N-channel push-button conditioner: one independent key_filter_ch per key bit.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int N          = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int STABLE_CYC = 1_000_000,
  parameter int LONG_CYC   = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_pulse,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long,
  output logic [N-1:0] key_state
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    key_filter_ch #(
      .ACTIVE_LOW(ACTIVE_LOW),
      .STABLE_CYC(STABLE_CYC),
      .LONG_CYC  (LONG_CYC)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key        (key[i]),
      .key_pulse  (key_pulse[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_state  (key_state[i])
    );
  end

endmodule
